// File: rtl/bp_io_cmd_arbiter_if.sv
// Command/response bundle between the NBF loader, the ethernet bridge and the processor IO port.
// The arbiter connects through the slave modport; the environment drives through master.
interface bp_io_cmd_arbiter_if #(parameter int msg_width_p = 128);
    logic [1:0][msg_width_p-1:0] req_cmd_i;
    logic [1:0]                  req_cmd_v_i;
    logic [1:0]                  req_cmd_ready_and_o;
    logic [msg_width_p-1:0]      cmd_o;
    logic                        cmd_v_o;
    logic                        cmd_ready_and_i;
    logic [msg_width_p-1:0]      resp_i;
    logic                        resp_v_i;
    logic                        resp_yumi_o;
    logic [1:0][msg_width_p-1:0] req_resp_o;
    logic [1:0]                  req_resp_v_o;
    logic [1:0]                  req_resp_ready_and_i;
    logic                        err_unexpected_resp_o;
    logic [1:0][15:0]            grant_cnt_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, cmd_ready_and_i, resp_i, resp_v_i, req_resp_ready_and_i,
        output req_cmd_ready_and_o, cmd_o, cmd_v_o, resp_yumi_o, req_resp_o, req_resp_v_o,
               err_unexpected_resp_o, grant_cnt_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, cmd_ready_and_i, resp_i, resp_v_i, req_resp_ready_and_i,
        input  req_cmd_ready_and_o, cmd_o, cmd_v_o, resp_yumi_o, req_resp_o, req_resp_v_o,
               err_unexpected_resp_o, grant_cnt_o
    );
endinterface

// File: rtl/bp_io_cmd_arbiter.sv
// Two-requester round-robin IO command arbiter with an in-order owner tag FIFO for response routing.
// Optional per-requester grant counters are built when BP_IO_ARB_GRANT_STATS_EN is defined.
module bp_io_cmd_arbiter #(
    parameter int msg_width_p   = 128,
    parameter int outstanding_p = 4,
    parameter int credit_p      = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bp_io_cmd_arbiter_if.slave   io
);
    localparam int ptr_w = $clog2(outstanding_p);
    localparam int cnt_w = ptr_w + 1;
    localparam int crd_w = $clog2(credit_p) + 1;
    localparam logic [cnt_w-1:0] depth_c      = cnt_w'(outstanding_p);
    localparam logic [crd_w-1:0] credit_max_c = crd_w'(credit_p);

    logic                  tag_mem [outstanding_p];
    logic [ptr_w-1:0]      wr_ptr;
    logic [ptr_w-1:0]      rd_ptr;
    logic [cnt_w-1:0]      count;
    logic [1:0][crd_w-1:0] credit;
    logic [1:0][crd_w-1:0] credit_nxt;
    logic                  last_grant;
    logic                  err;

    logic       full;
    logic       empty;
    logic [1:0] elig;
    logic       any;
    logic       winner;
    logic       head;
    logic       push;
    logic       pop;

    // Outputs are gated with reset so the block is silent while reset_n_i is low.
    always_comb begin
        full  = (count == depth_c);
        empty = (count == '0);
        for (int i = 0; i < 2; i++) begin
            elig[i] = io.req_cmd_v_i[i] & (credit[i] < credit_max_c) & ~full;
        end
        any    = (|elig) & reset_n_i;
        winner = (elig == 2'b11) ? ~last_grant : elig[1];
        head   = tag_mem[rd_ptr];
        push   = any & io.cmd_ready_and_i;
        pop    = reset_n_i & io.resp_v_i & ~empty & io.req_resp_ready_and_i[head];
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            credit_nxt[i] = credit[i];
            if (push && (winner == 1'(i))) credit_nxt[i] = credit_nxt[i] + crd_w'(1);
            if (pop && (head == 1'(i)))    credit_nxt[i] = credit_nxt[i] - crd_w'(1);
        end
    end

    always_comb begin
        io.cmd_v_o = any;
        io.cmd_o   = any ? io.req_cmd_i[winner] : '0;
        for (int i = 0; i < 2; i++) begin
            io.req_cmd_ready_and_o[i] = push & (winner == 1'(i));
            io.req_resp_v_o[i]        = reset_n_i & io.resp_v_i & ~empty & (head == 1'(i));
            io.req_resp_o[i]          = reset_n_i ? io.resp_i : '0;
        end
        io.resp_yumi_o           = pop;
        io.err_unexpected_resp_o = err;
    end

    // last_grant resets to 1 so requester 0 wins the first contested round.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit     <= '0;
            last_grant <= 1'b1;
            err        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            credit <= credit_nxt;
            if (push) last_grant <= winner;
            if (io.resp_v_i && empty) err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr] <= winner;
    end

`ifdef BP_IO_ARB_GRANT_STATS_EN
    logic [1:0][15:0] grant_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push && (winner == 1'(i)) && (grant_cnt[i] != 16'hFFFF))
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
        end
    end

    assign io.grant_cnt_o = grant_cnt;
`else
    assign io.grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Bench for bp_io_cmd_arbiter: vector table, directed corner sequences and random traffic
// compared against an owner-queue reference model.
module tb_bp_io_cmd_arbiter;
    localparam int W    = 128;
    localparam int OUT  = 4;
    localparam int CRED = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_io_cmd_arbiter_if #(.msg_width_p(W)) bus ();

    bp_io_cmd_arbiter #(.msg_width_p(W), .outstanding_p(OUT), .credit_p(CRED)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of owners of commands in flight, in issue order.
    int         q[$];
    int         cr[2];
    int         prefer;
    bit         err_m;
    logic [15:0] gcnt[2];

    logic       s_cmd_v;
    logic [1:0] s_rdy;
    logic [1:0] s_rspv;
    logic       s_yumi;

    typedef struct {
        logic [1:0] v;
        logic       crdy;
        logic       rv;
        logic [1:0] rrdy;
        logic       e_cmd_v;
        logic [1:0] e_rdy;
        logic [1:0] e_rspv;
        logic       e_yumi;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic crdy, input logic rv, input logic [1:0] rrdy);
        bus.req_cmd_v_i          = v;
        bus.cmd_ready_and_i      = crdy;
        bus.resp_v_i             = rv;
        bus.req_resp_ready_and_i = rrdy;
    endtask

    task automatic model_clear();
        q.delete();
        cr[0]   = 0;
        cr[1]   = 0;
        prefer  = 0;
        err_m   = 1'b0;
        gcnt[0] = 16'h0;
        gcnt[1] = 16'h0;
    endtask

    // Called at posedge+1; checks mid-cycle, then advances the model across the next edge.
    task automatic cycle();
        bit el[2];
        bit any;
        bit empty;
        bit yumi;
        bit push;
        int w;
        int head;
        logic [1:0] erdy;
        logic [1:0] erspv;
        logic [15:0] eg0;
        logic [15:0] eg1;
        #4;
        for (int i = 0; i < 2; i++)
            el[i] = bus.req_cmd_v_i[i] && (cr[i] < CRED) && (q.size() < OUT);
        any = el[0] || el[1];
        if (el[0] && el[1]) w = prefer;
        else                w = el[1] ? 1 : 0;
        push  = any && bus.cmd_ready_and_i;
        empty = (q.size() == 0);
        head  = empty ? 0 : q[0];
        yumi  = bus.resp_v_i && !empty && bus.req_resp_ready_and_i[head];
        erdy  = 2'b00;
        erspv = 2'b00;
        if (push) erdy[w] = 1'b1;
        if (bus.resp_v_i && !empty) erspv[head] = 1'b1;
`ifdef BP_IO_ARB_GRANT_STATS_EN
        eg0 = gcnt[0];
        eg1 = gcnt[1];
`else
        eg0 = 16'h0;
        eg1 = 16'h0;
`endif
        chk("cmd_v", W'(bus.cmd_v_o), W'(any));
        if (any) chk("cmd_data", bus.cmd_o, bus.req_cmd_i[w]);
        chk("cmd_ready", W'(bus.req_cmd_ready_and_o), W'(erdy));
        chk("resp_v", W'(bus.req_resp_v_o), W'(erspv));
        chk("resp_yumi", W'(bus.resp_yumi_o), W'(yumi));
        chk("resp_lane0", bus.req_resp_o[0], bus.resp_i);
        chk("resp_lane1", bus.req_resp_o[1], bus.resp_i);
        chk("err", W'(bus.err_unexpected_resp_o), W'(err_m));
        chk("grant_cnt0", W'(bus.grant_cnt_o[0]), W'(eg0));
        chk("grant_cnt1", W'(bus.grant_cnt_o[1]), W'(eg1));
        s_cmd_v = bus.cmd_v_o;
        s_rdy   = bus.req_cmd_ready_and_o;
        s_rspv  = bus.req_resp_v_o;
        s_yumi  = bus.resp_yumi_o;
        @(posedge clk);
        if (yumi) begin
            void'(q.pop_front());
            cr[head]--;
        end
        if (push) begin
            q.push_back(w);
            cr[w]++;
            prefer = 1 - w;
            if (gcnt[w] != 16'hFFFF) gcnt[w] = gcnt[w] + 16'd1;
        end
        if (bus.resp_v_i && empty) err_m = 1'b1;
        #1;
    endtask

    // Reset with busy inputs to show every output is held at 0.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        #1;
        chk("rst_cmd_v", W'(bus.cmd_v_o), W'(0));
        chk("rst_cmd", bus.cmd_o, W'(0));
        chk("rst_cmd_ready", W'(bus.req_cmd_ready_and_o), W'(0));
        chk("rst_resp_v", W'(bus.req_resp_v_o), W'(0));
        chk("rst_yumi", W'(bus.resp_yumi_o), W'(0));
        chk("rst_resp_lanes", bus.req_resp_o[0] | bus.req_resp_o[1], W'(0));
        chk("rst_err", W'(bus.err_unexpected_resp_o), W'(0));
        chk("rst_grant_cnt", W'(bus.grant_cnt_o), W'(0));
        model_clear();
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0};
        tbl[2] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0};
        tbl[3] = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[4] = '{2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1};
        tbl[5] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 2'b10, 1'b0};
        tbl[6] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 2'b10, 1'b1};
        tbl[7] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1};
        tbl[8] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b10, 1'b1};
        tbl[9] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1};

        bus.req_cmd_i[0] = {4{32'hA0A0_0000}};
        bus.req_cmd_i[1] = {4{32'h5B5B_1111}};
        bus.resp_i       = {4{32'hC3C3_2222}};
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        #2;
        do_reset();

        // Vector table from a fresh reset
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].v, tbl[k].crdy, tbl[k].rv, tbl[k].rrdy);
            cycle();
            chk($sformatf("tbl%0d_cmd_v", k), W'(s_cmd_v), W'(tbl[k].e_cmd_v));
            chk($sformatf("tbl%0d_ready", k), W'(s_rdy), W'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_resp_v", k), W'(s_rspv), W'(tbl[k].e_rspv));
            chk($sformatf("tbl%0d_yumi", k), W'(s_yumi), W'(tbl[k].e_yumi));
        end

        // Requester 0 alone runs into its credit limit
        do_reset();
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        cycle(); chk("cred_first", W'(s_rdy), W'(2'b01));
        cycle(); chk("cred_second", W'(s_rdy), W'(2'b01));
        cycle(); chk("cred_stall", W'(s_cmd_v), W'(0));
        drive(2'b01, 1'b1, 1'b1, 2'b01);
        cycle(); chk("cred_resp_yumi", W'(s_yumi), W'(1));
        drive(2'b01, 1'b1, 1'b0, 2'b00);
        cycle(); chk("cred_third", W'(s_rdy), W'(2'b01));
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        repeat (2) cycle();

        // Continuous contention alternates, responses follow issue order
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("rr_grant%0d", k), W'(s_rdy), W'((k % 2 == 0) ? 2'b01 : 2'b10));
        end
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("rr_route%0d", k), W'(s_rspv), W'((k % 2 == 0) ? 2'b01 : 2'b10));
        end

        // Full FIFO blocks a push even when a pop happens in the same cycle
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        repeat (4) cycle();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        cycle();
        chk("full_pop", W'(s_yumi), W'(1));
        chk("full_block", W'(s_rdy), W'(2'b00));
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        cycle();
        chk("full_after", W'(s_rdy), W'(2'b01));
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        repeat (4) cycle();

        // Head owned by requester 1, lane 1 back-pressures
        do_reset();
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        cycle();
        drive(2'b00, 1'b1, 1'b1, 2'b01);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("bp_yumi%0d", k), W'(s_yumi), W'(0));
            chk($sformatf("bp_lanes%0d", k), W'(s_rspv), W'(2'b10));
        end
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        cycle();
        chk("bp_release", W'(s_yumi), W'(1));

        // Unexpected response sets a sticky error until reset
        drive(2'b00, 1'b1, 1'b1, 2'b11);
        cycle();
        chk("unexp_yumi", W'(s_yumi), W'(0));
        drive(2'b00, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("unexp_sticky%0d", k), W'(bus.err_unexpected_resp_o), W'(1));
            cycle();
        end
        do_reset();
        chk("unexp_cleared", W'(bus.err_unexpected_resp_o), W'(0));

        // Random traffic, with occasional resets while commands are in flight
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            bus.req_cmd_i[0] = {$urandom, $urandom, $urandom, $urandom};
            bus.req_cmd_i[1] = {$urandom, $urandom, $urandom, $urandom};
            bus.resp_i       = {$urandom, $urandom, $urandom, $urandom};
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)));
            cycle();
        end

        // Grant counters
        do_reset();
`ifdef BP_IO_ARB_GRANT_STATS_EN
        drive(2'b10, 1'b1, 1'b0, 2'b00);
        cycle();
        drive(2'b10, 1'b1, 1'b1, 2'b11);
        for (int k = 1; k < 70000; k++) cycle();
        chk("stats_sat1", W'(bus.grant_cnt_o[1]), W'(16'hFFFF));
        chk("stats_zero0", W'(bus.grant_cnt_o[0]), W'(0));
`else
        drive(2'b11, 1'b1, 1'b0, 2'b00);
        repeat (3) cycle();
        chk("stats_off0", W'(bus.grant_cnt_o[0]), W'(0));
        chk("stats_off1", W'(bus.grant_cnt_o[1]), W'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
- Shares one BedRock IO command/response channel into the tethered processor between two requesters: requester 0 (NBF loader) and requester 1 (ethernet host bridge).
- Round-robin grants commands and records the owner of each command in an in-order tag FIFO. Routes each returning response to the requester that owns the oldest outstanding command.
- Sits between the loader/bridge and the processor IO command/response ports, in the bp_clk_i domain.

Parameters:
- msg_width_p, 128, width of one BedRock IO message (header plus data), opaque to this block.
- outstanding_p, 4, tag FIFO depth; maximum total commands in flight. Power of two, ≥2.
- credit_p, 2, maximum commands in flight per requester. Range 1..outstanding_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_cmd_i  in  2×msg_width_p  command per requester; index 0 is NBF, index 1 is ethernet.
- req_cmd_v_i  in  2  command valid per requester.
- req_cmd_ready_and_o  out  2  command accepted when high together with valid.
- cmd_o  out  msg_width_p  command to processor.
- cmd_v_o  out  1  command valid.
- cmd_ready_and_i  in  1  processor accepts the command.
- resp_i  in  msg_width_p  response from processor.
- resp_v_i  in  1  response valid.
- resp_yumi_o  out  1  response consumed.
- req_resp_o  out  2×msg_width_p  response per requester (both lanes carry resp_i).
- req_resp_v_o  out  2  response valid per requester.
- req_resp_ready_and_i  in  2  requester accepts the response.
- err_unexpected_resp_o  out  1  sticky: a response arrived while no command was outstanding.
- grant_cnt_o  out  2×16  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - Round-robin pointer selects requester 0 first.
  - Tag FIFO empty; credit counters 0; err flag 0; grant counters 0.
  - All outputs are 0 during reset.
- Eligibility: requester i is eligible when req_cmd_v_i[i]=1, credit_cnt[i]<credit_p, and the tag FIFO is not full.
  - Full blocks pushes even when a pop happens in the same cycle.
- Grant:
  - Combinational in the same cycle; zero-latency pass-through, no command register.
  - With one eligible requester, it wins.
  - With both eligible, the requester not granted most recently wins.
  - cmd_o and cmd_v_o come from the winner; cmd_v_o=0 when nothing is eligible.
  - req_cmd_ready_and_o[i] = (winner==i) & cmd_ready_and_i.
  - Grant is not held across stalls. If the processor is not ready, arbitration re-evaluates the next cycle.
  - cmd_v_o never depends on cmd_ready_and_i.
- On command handshake (cmd_v_o & cmd_ready_and_i):
  - Push the winner id into the tag FIFO.
  - Increment credit_cnt[winner].
  - Move the last-granted pointer to the winner.
- Response routing:
  - head = tag FIFO head.
  - req_resp_v_o[head] = resp_v_i & ~empty; the other lane's valid is 0.
  - resp_yumi_o = resp_v_i & ~empty & req_resp_ready_and_i[head].
  - On yumi: pop the FIFO and decrement credit_cnt[head].
  - Response latency is 0 cycles (combinational route).
- Simultaneous push and pop in the same cycle:
  - FIFO count is unchanged.
  - If the same requester, its credit is unchanged.
  - If different requesters, one credit increments and the other decrements.
- Unexpected response (resp_v_i & empty):
  - No yumi; the response is held by the processor.
  - err_unexpected_resp_o sets on the next edge and stays set until reset.
- Pointer wrap: FIFO read/write pointers are log2(outstanding_p) bits and wrap modulo depth. A separate count register of log2(outstanding_p)+1 bits distinguishes full from empty.
- Credit counters are log2(credit_p)+1 bits and never overflow or underflow (guarded by eligibility and ~empty).
- Reset mid-operation discards all in-flight tags; responses arriving afterward are flagged unexpected.

Optional Feature:
- Macro: BP_IO_ARB_GRANT_STATS_EN.
- Defined: grant_cnt_o[i] increments on each command handshake granted to requester i, saturating at 16'hFFFF. Cleared by reset.
- Undefined: counter logic is not compiled and grant_cnt_o is tied to 0.

Test Plan:
- Only requester 0 sends 3 commands, cmd_ready_and_i=1, credit_p=2:
  - First 2 are accepted on consecutive cycles; the third stalls.
  - One response for requester 0 → third accepted the next cycle.
- Both requesters hold valid continuously, processor always ready:
  - Grant order is 0,1,0,1.
  - Responses are routed in the same order to lanes 0,1,0,1.
- 4 commands in flight (FIFO full, credits 2/2) and a response popped in the same cycle a new command is valid → command is not accepted that cycle; accepted the cycle after.
- Head owner is requester 1 with req_resp_ready_and_i[1]=0 for 5 cycles → resp_yumi_o=0 and req_resp_v_o[0]=0 throughout; pop occurs once ready rises.
- resp_v_i=1 with FIFO empty → resp_yumi_o=0; err_unexpected_resp_o=1 from the next cycle and stays set; reset_n_i pulse clears it.
- With BP_IO_ARB_GRANT_STATS_EN defined, grant 70000 commands to requester 1 → grant_cnt_o[1]=16'hFFFF and grant_cnt_o[0]=0. Without the macro, both counters read 0.
